// File: rtl/nonsynth_ethernet_sender_if.sv
// AXI-Stream transmit bus between the frame source and the MAC TX port.
// Master drives beat data/control, slave returns tready.
// tuser is carried for completeness; this source never aborts a frame.
interface nonsynth_ethernet_sender_if #(
  parameter int send_width_p = 8
);
  logic [send_width_p*8-1:0] tdata;
  logic [send_width_p-1:0]   tkeep;
  logic                      tvalid;
  logic                      tready;
  logic                      tlast;
  logic                      tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/nonsynth_ethernet_sender.sv
// TX frame source: host-filled word buffer streamed out as AXIS beats, tkeep on last beat.
// Latency: first beat valid 1 cycle after an accepted send, then one beat per cycle.
// Backpressure: beat held stable while tvalid && !tready; host writes/sends ignored while busy.
module nonsynth_ethernet_sender #(
  parameter  int send_width_p  = 8,
  parameter  int buf_size_p    = ((1556-1)/send_width_p+1)*send_width_p,
  localparam int addr_width_lp = $clog2(buf_size_p/send_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      buffer_write_en_i,
  input  logic [addr_width_lp-1:0]  buffer_write_addr_i,
  input  logic [send_width_p*8-1:0] buffer_write_data_i,
  input  logic [15:0]               packet_size_i,
  input  logic                      send_i,
  input  logic                      clear_status_i,
  output logic                      busy_o,
  output logic                      done_r_o,
  output logic                      error_r_o,
  nonsynth_ethernet_sender_if.master tx_axis
);

  localparam int words_lp = buf_size_p/send_width_p;
  localparam logic [addr_width_lp:0]   words_w    = (addr_width_lp+1)'(words_lp);
  localparam logic [15:0]              buf_size_w = 16'(buf_size_p);
  localparam logic [addr_width_lp-1:0] one_w      = addr_width_lp'(1);

  // The keep/beat arithmetic below assumes 8-byte beats.
  generate
    if (send_width_p != 8) begin : g_width_check
      $error("nonsynth_ethernet_sender: only send_width_p == 8 is supported");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e                    state_r, state_n;
  logic [send_width_p*8-1:0] mem_r [words_lp];
  logic [addr_width_lp-1:0]  ptr_r;
  logic [addr_width_lp-1:0]  beats_r;
  logic [send_width_p-1:0]   last_keep_r;

  logic                      size_ok;
  logic                      send_ok;
  logic                      size_bad;
  logic                      beat_fire;
  logic                      last_beat;
  logic [addr_width_lp-1:0]  beats_calc;
  logic [send_width_p-1:0]   keep_calc;

  // Send qualification and per-frame length/keep derivation from the requested size.
  always_comb begin
    size_ok    = (packet_size_i != 16'd0) && (packet_size_i <= buf_size_w);
    send_ok    = (state_r == ST_IDLE) && send_i && size_ok;
    size_bad   = (state_r == ST_IDLE) && send_i && !size_ok;
    // Legal sizes stay far below 16-bit overflow, so the +7 cannot wrap.
    beats_calc = addr_width_lp'((packet_size_i + 16'd7) >> 3);
    keep_calc  = (packet_size_i[2:0] == 3'd0) ? {send_width_p{1'b1}}
                 : send_width_p'((16'd1 << packet_size_i[2:0]) - 16'd1);
    last_beat  = (state_r == ST_SEND) && (ptr_r == beats_r - one_w);
    beat_fire  = (state_r == ST_SEND) && tx_axis.tready;
  end

  // Frame buffer: not reset; host writes land only while idle and in range.
  always_ff @(posedge clk_i) begin
    if (buffer_write_en_i && (state_r == ST_IDLE)
        && ({1'b0, buffer_write_addr_i} < words_w)) begin
      mem_r[buffer_write_addr_i] <= buffer_write_data_i;
    end
  end

  // State register; async reset drops tvalid immediately, truncating any frame.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_r <= ST_IDLE;
    else         state_r <= state_n;
  end

  // Next-state: start on a legal send, return to idle on the last handshake.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE: if (send_ok) state_n = ST_SEND;
      ST_SEND: if (beat_fire && last_beat) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Beat pointer and latched frame geometry.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_r       <= '0;
      beats_r     <= '0;
      last_keep_r <= '0;
    end else if (send_ok) begin
      ptr_r       <= '0;
      beats_r     <= beats_calc;
      last_keep_r <= keep_calc;
    end else if (beat_fire && !last_beat) begin
      ptr_r       <= ptr_r + one_w;
    end
  end

  // Sticky status flags; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      done_r_o  <= 1'b0;
      error_r_o <= 1'b0;
    end else begin
      if (beat_fire && last_beat) done_r_o  <= 1'b1;
      else if (clear_status_i)    done_r_o  <= 1'b0;
      if (size_bad)               error_r_o <= 1'b1;
      else if (clear_status_i)    error_r_o <= 1'b0;
    end
  end

  // AXIS outputs come straight from registered state; data is a read at the current pointer.
  always_comb begin
    busy_o         = (state_r == ST_SEND);
    tx_axis.tvalid = (state_r == ST_SEND);
    tx_axis.tlast  = last_beat;
    tx_axis.tkeep  = last_beat ? last_keep_r : {send_width_p{1'b1}};
    tx_axis.tdata  = mem_r[ptr_r];
    tx_axis.tuser  = 1'b0;
  end

endmodule

// File: tb/tb_nonsynth_ethernet_sender.sv
// Randomized scoreboard bench for nonsynth_ethernet_sender.
// Expected beats are derived from a plain array model of the buffer and the size rules.
// A negedge monitor pops and compares every handshake and checks stall stability.
module tb_nonsynth_ethernet_sender;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        buffer_write_en_i = 1'b0;
  logic [7:0]  buffer_write_addr_i = '0;
  logic [63:0] buffer_write_data_i = '0;
  logic [15:0] packet_size_i = '0;
  logic        send_i = 1'b0;
  logic        clear_status_i = 1'b0;
  logic        busy_o, done_r_o, error_r_o;

  nonsynth_ethernet_sender_if tx_if ();

  nonsynth_ethernet_sender dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .buffer_write_en_i   (buffer_write_en_i),
    .buffer_write_addr_i (buffer_write_addr_i),
    .buffer_write_data_i (buffer_write_data_i),
    .packet_size_i       (packet_size_i),
    .send_i              (send_i),
    .clear_status_i      (clear_status_i),
    .busy_o              (busy_o),
    .done_r_o            (done_r_o),
    .error_r_o           (error_r_o),
    .tx_axis             (tx_if)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] model_mem [195];
  int          n_checks = 0;
  int          n_fail = 0;
  int          beats_seen = 0;
  bit          frame_active = 1'b0;
  int          rdy_mode = 0;
  int          rdy_cnt = 0;
  logic [5:0]  rdy_pat = 6'b101001;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Downstream ready generator: always, fixed 1,0,0,1,0,1 pattern, or random.
  initial begin
    tx_if.tready = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
        0:       tx_if.tready = 1'b1;
        1: begin
          tx_if.tready = rdy_pat[rdy_cnt % 6];
          rdy_cnt++;
        end
        default: tx_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares each handshake against the scoreboard and checks held beats.
  beat_t prev_beat;
  bit    prev_stall = 1'b0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", tx_if.tdata, prev_beat.data);
        check("stall_ctl", {tx_if.tvalid, tx_if.tkeep, tx_if.tlast},
              {1'b1, prev_beat.keep, prev_beat.last});
      end
      if (tx_if.tvalid && tx_if.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %h with no beat expected", tx_if.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          check("beat_data", tx_if.tdata, e.data);
          check("beat_ctl", {tx_if.tkeep, tx_if.tlast, tx_if.tuser}, {e.keep, e.last, 1'b0});
        end
        beats_seen++;
      end
      prev_stall = tx_if.tvalid && !tx_if.tready;
      prev_beat  = '{data: tx_if.tdata, keep: tx_if.tkeep, last: tx_if.tlast};
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_word(input int addr, input logic [63:0] data);
    buffer_write_en_i   = 1'b1;
    buffer_write_addr_i = 8'(addr);
    buffer_write_data_i = data;
    tick();
    buffer_write_en_i = 1'b0;
    if (!frame_active && addr < 195) model_mem[addr] = data;
  endtask

  // Reference: ceil(size/8) beats of buffer words; last beat keeps size%8 low bytes (all if 0).
  task automatic push_frame(input int size);
    int n;
    int rem;
    beat_t e;
    n   = (size + 7) / 8;
    rem = size % 8;
    for (int i = 0; i < n; i++) begin
      e.data = model_mem[i];
      e.last = (i == n - 1);
      e.keep = (e.last && rem != 0) ? 8'((2 ** rem) - 1) : 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input int size);
    bit legal;
    legal = (size >= 1) && (size <= 1560) && !frame_active;
    packet_size_i = 16'(size);
    send_i = 1'b1;
    if (legal) begin
      push_frame(size);
      frame_active = 1'b1;
    end
    tick();
    send_i = 1'b0;
    if (legal) begin
      check("first_beat_valid", tx_if.tvalid, 1'b1);
      check("busy_in_frame", busy_o, 1'b1);
    end
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (busy_o && cyc < 2000) begin
      tick();
      cyc++;
    end
    check("frame_timeout", busy_o, 1'b0);
    check("done_after_frame", done_r_o, 1'b1);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    frame_active = 1'b0;
  endtask

  task automatic clear_status();
    clear_status_i = 1'b1;
    tick();
    clear_status_i = 1'b0;
    check("clear_flags", {done_r_o, error_r_o}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int cyc;
    int size;

    // Reset state
    #2;
    check("reset_outputs", {busy_o, done_r_o, error_r_o, tx_if.tvalid}, 4'b0000);
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    tick();
    check("post_reset_idle", {busy_o, tx_if.tvalid}, 2'b00);

    // Full 64-byte frame of known data
    for (int i = 0; i < 8; i++) write_word(i, 64'h0101010101010101 * 64'(i + 1));
    send(64);
    wait_done();

    // Partial last beat, then single-byte frame
    clear_status();
    send(61);
    wait_done();
    clear_status();
    send(1);
    wait_done();

    // Patterned backpressure
    clear_status();
    rdy_mode = 1;
    rdy_cnt  = 0;
    send(64);
    wait_done();
    rdy_mode = 0;

    // Maximum size, then illegal sizes
    for (int i = 0; i < 195; i++) write_word(i, {$urandom, $urandom});
    clear_status();
    send(1560);
    wait_done();
    send(0);
    check("err_size0", {error_r_o, tx_if.tvalid, busy_o}, 3'b100);
    check("done_kept", done_r_o, 1'b1);
    clear_status();
    send(1561);
    check("err_size1561", {error_r_o, tx_if.tvalid, busy_o}, 3'b100);
    tick();
    check("err_no_valid", tx_if.tvalid, 1'b0);
    clear_status();

    // Send and write during a frame are ignored
    for (int i = 0; i < 8; i++) write_word(i, {$urandom, $urandom});
    send(64);
    packet_size_i       = 16'd8;
    send_i              = 1'b1;
    buffer_write_en_i   = 1'b1;
    buffer_write_addr_i = 8'd0;
    buffer_write_data_i = 64'hDEAD;
    tick();
    send_i            = 1'b0;
    buffer_write_en_i = 1'b0;
    wait_done();
    check("busy_send_no_error", error_r_o, 1'b0);
    clear_status();
    send(8);
    wait_done();

    // Reset in the middle of a frame
    clear_status();
    base = beats_seen;
    send(64);
    cyc = 0;
    while (beats_seen < base + 3 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("three_beats_seen", 64'(beats_seen - base), 64'd3);
    reset_i = 1'b1;
    exp_q.delete();
    frame_active = 1'b0;
    #1;
    check("reset_midframe", {tx_if.tvalid, busy_o, done_r_o, error_r_o}, 4'b0000);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    tick();
    write_word(0, {$urandom, $urandom});
    write_word(1, {$urandom, $urandom});
    send(16);
    wait_done();

    // Random sizes, data and backpressure
    rdy_mode = 2;
    for (int k = 0; k < 6; k++) begin
      size = $urandom_range(1, 1560);
      for (int i = 0; i < (size + 7) / 8; i++) write_word(i, {$urandom, $urandom});
      clear_status();
      send(size);
      wait_done();
    end
    rdy_mode = 0;

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nonsynth_ethernet_sender.md
Name: nonsynth_ethernet_sender

Overview:
Non-synthesizable TX-side frame source for Ethernet core cosimulation. The host fills a word-addressed frame buffer, programs a byte length and pulses send. The block then streams the frame as AXI-Stream beats into the MAC TX interface, using tkeep on the final beat, and raises a sticky completion flag. It is the transmit counterpart of the RX capture buffer.

Parameters:
send_width_p, 8, bytes per AXIS beat; only 8 is supported, and an assertion fires otherwise.
buf_size_p, ((1556-1)/send_width_p+1)*send_width_p = 1560, frame buffer size in bytes.
addr_width_lp, $clog2(buf_size_p/send_width_p) = 8, buffer word address width (local).

Ports:
clk_i  in  1  clock; all state changes on its rising edge
reset_i  in  1  asynchronous, active-high reset
buffer_write_en_i  in  1  write one buffer word this cycle
buffer_write_addr_i  in  addr_width_lp  word address of the write
buffer_write_data_i  in  send_width_p*8  write data; byte 0 is in bits [7:0]
packet_size_i  in  16  frame length in bytes; sampled only on an accepted send_i
send_i  in  1  start-transmission pulse
clear_status_i  in  1  clears done_r_o and error_r_o
busy_o  out  1  high while a frame is being sent
done_r_o  out  1  sticky: last beat accepted
error_r_o  out  1  sticky: send_i rejected because of an illegal size
tx_axis_tdata_o  out  send_width_p*8  beat data
tx_axis_tkeep_o  out  send_width_p  byte enables
tx_axis_tvalid_o  out  1  beat valid
tx_axis_tready_i  in  1  downstream ready
tx_axis_tlast_o  out  1  final beat of the frame
tx_axis_tuser_o  out  1  tied to 0 (no aborts generated)

Behaviour:
- Reset values: state IDLE, ptr 0, busy_o 0, done_r_o 0, error_r_o 0, tvalid 0. tdata/tkeep/tlast are don't-care while tvalid is 0. Buffer contents are not reset.
- Buffer: buf_size_p/8 = 195 words. A write is accepted only when busy_o=0; writes while busy are dropped. Write addresses >= 195 are ignored.
- FSM IDLE:
  - send_i with 1 <= packet_size_i <= buf_size_p: latch beats_r = (size+7)>>3 and last_keep_r, clear ptr, go to SEND.
  - send_i with size 0 or > buf_size_p: set error_r_o, stay IDLE.
- last_keep_r: size[2:0]==0 gives 8'hFF; otherwise (1<<size[2:0])-1 (e.g. 5 gives 8'h1F).
- FSM SEND:
  - tvalid=1, busy=1, tdata=buffer[ptr].
  - tlast = (ptr == beats_r-1).
  - tkeep = tlast ? last_keep_r : 8'hFF.
  - On tvalid && tready: if tlast, go to IDLE and set done_r_o (visible next cycle); else ptr+1.
  - tvalid, tlast and tkeep are functions of registered state only; tdata is a direct read at the registered ptr.
  - Outputs are stable while tvalid && !tready (AXIS rule): no dropping, no changes.
- First beat tvalid appears 1 cycle after the accepted send_i. An N-beat frame with tready held high takes N cycles; there are no idle cycles between beats.
- send_i while SEND: ignored; the size and the current frame are unaffected.
- send_i in the same cycle as the last-beat handshake: ignored (state is still SEND).
- clear_status_i clears both flags. When clear_status_i coincides with done/error being set, the set wins.
- done_r_o does not block a new send; the host clears it.
- Reset mid-frame: tvalid deasserts immediately (asynchronous) with no tlast. The frame is truncated; the partial frame is the downstream's problem.
- Width arithmetic: beats_r and ptr are addr_width_lp bits wide; the maximum beats is 195, which fits.

Test Plan:
1. Write words 0..7 = 64'h0101..01 * (i+1), size=64, send → 8 beats of the written data, tkeep 8'hFF on every beat, tlast only on beat 8; done_r_o=1 the cycle after; busy_o low.
2. size=61, same data → 8 beats, beat 8 tkeep=8'h1F with tlast; size=1 → one beat, tkeep=8'h01, tlast=1.
3. size=64 with tready pattern 1,0,0,1,0,1,... → tdata/tkeep/tlast held stable during every stall, exactly 8 handshakes in order, no duplicates.
4. size=1560 → 195 beats, last tkeep=8'hFF. size=0 and size=1561 → error_r_o=1, tvalid never asserts; clear_status_i → both flags 0.
5. During SEND, pulse send_i with size=8 and write word 0 with 64'hDEAD → the frame in flight is unchanged (length and data); buffer word 0 still holds the old value afterwards.
6. Assert reset_i after the 3rd beat of a 64-byte frame → tvalid=0 in the same cycle, flags 0. After release, rewrite the buffer and send size=16 → 2 clean beats, done_r_o=1.
